// File: rtl/mips_top.sv
// Single-cycle MIPS subsystem: core + 64-word IMEM ROM + 64-word DMEM; one instruction per clk.
// Outputs are the combinational DMEM write port of the current instruction; no backpressure.
module mips_top (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] writedata,
   output logic [31:0] dataadr,
   output logic        memwrite
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [31:0] imem   [0:63];
   logic [31:0] dmem_q [0:63];
   logic [31:0] rf_q   [0:31];

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wa;
   logic [31:0] signimm;

   logic        regwrite, regdst, alusrc, branch, is_sw, memtoreg, jump;
   logic [1:0]  aluop;
   logic [2:0]  aluctl;

   logic [31:0] srca, srcb, rd2, aluresult, readdata, wd;
   logic        zero;
   logic [31:0] pc_plus4, pc_branch;

   initial begin
      for (int i = 0; i < 64; i++)
         imem[i] = 32'h0;
      imem[0]  = 32'h20020005;
      imem[1]  = 32'h2003000c;
      imem[2]  = 32'h2067fff7;
      imem[3]  = 32'h00e22025;
      imem[4]  = 32'h00642824;
      imem[5]  = 32'h00a42820;
      imem[6]  = 32'h10a7000a;
      imem[7]  = 32'h0064202a;
      imem[8]  = 32'h10800001;
      imem[9]  = 32'h20050000;
      imem[10] = 32'h00e2202a;
      imem[11] = 32'h00853820;
      imem[12] = 32'h00e23822;
      imem[13] = 32'hac670044;
      imem[14] = 32'h8c020050;
      imem[15] = 32'h08000011;
      imem[16] = 32'h20020001;
      imem[17] = 32'hac020054;
   end

   assign instr   = imem[pc_q[7:2]];
   assign op      = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign funct   = instr[5:0];
   assign signimm = {{16{instr[15]}}, instr[15:0]};

   // Unlisted opcodes leave every control low: no writes, fall through to PC+4.
   always_comb begin
      regwrite = 1'b0;
      regdst   = 1'b0;
      alusrc   = 1'b0;
      branch   = 1'b0;
      is_sw    = 1'b0;
      memtoreg = 1'b0;
      jump     = 1'b0;
      aluop    = 2'b00;
      case (op)
         OP_RTYPE: begin regwrite = 1'b1; regdst = 1'b1; aluop = 2'b10; end
         OP_LW:    begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
         OP_SW:    begin alusrc = 1'b1; is_sw = 1'b1; end
         OP_BEQ:   begin branch = 1'b1; aluop = 2'b01; end
         OP_ADDI:  begin regwrite = 1'b1; alusrc = 1'b1; end
         OP_J:     begin jump = 1'b1; end
         default:  ;
      endcase
   end

   always_comb begin
      aluctl = ALU_ADD;
      case (aluop)
         2'b00: aluctl = ALU_ADD;
         2'b01: aluctl = ALU_SUB;
         default: begin
            case (funct)
               6'h20:   aluctl = ALU_ADD;
               6'h22:   aluctl = ALU_SUB;
               6'h24:   aluctl = ALU_AND;
               6'h25:   aluctl = ALU_OR;
               6'h2a:   aluctl = ALU_SLT;
               default: aluctl = ALU_ADD;
            endcase
         end
      endcase
   end

   assign srca = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rd2  = (rt == 5'd0) ? 32'd0 : rf_q[rt];
   assign srcb = alusrc ? signimm : rd2;

   always_comb begin
      aluresult = 32'd0;
      case (aluctl)
         ALU_AND: aluresult = srca & srcb;
         ALU_OR:  aluresult = srca | srcb;
         ALU_ADD: aluresult = srca + srcb;
         ALU_SUB: aluresult = srca - srcb;
         ALU_SLT: aluresult = {31'd0, ($signed(srca) < $signed(srcb))};
         default: aluresult = 32'd0;
      endcase
   end

   assign zero      = (aluresult == 32'd0);
   assign readdata  = dmem_q[aluresult[7:2]];
   assign wa        = regdst ? rd : rt;
   assign wd        = memtoreg ? readdata : aluresult;

   assign writedata = rd2;
   assign dataadr   = aluresult;
   assign memwrite  = is_sw & ~reset;

   assign pc_plus4  = pc_q + 32'd4;
   assign pc_branch = pc_plus4 + {signimm[29:0], 2'b00};

   always_comb begin
      pc_d = pc_plus4;
      if (jump)
         pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (branch && zero)
         pc_d = pc_branch;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= 32'd0;
      else
         pc_q <= pc_d;
   end

   // Register file is deliberately not reset; reset only suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && regwrite && (wa != 5'd0))
         rf_q[wa] <= wd;
   end

   always_ff @(posedge clk) begin
      if (memwrite)
         dmem_q[aluresult[7:2]] <= writedata;
   end

endmodule

// File: tb/tb_mips_top.sv
// Directed bench for mips_top: standard program, mid-run reset, $0 hardwiring, unsupported opcode.
module tb_mips_top;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] writedata;
   logic [31:0] dataadr;
   logic        memwrite;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] std_prog [0:17] = '{
      32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824, 32'h00a42820,
      32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
      32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011, 32'h20020001, 32'hac020054
   };

   mips_top dut (
      .clk       (clk),
      .reset     (reset),
      .writedata (writedata),
      .dataadr   (dataadr),
      .memwrite  (memwrite)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds reset for rel negedges, then releases 2 ns later and watches for the two stores.
   // Instruction k is visible at negedge rel+k, so the sw at k=12 lands at negedge rel+12.
   task automatic run_std(input string tag, input int rel);
      int stores;
      int first_exp;
      stores    = 0;
      first_exp = rel + 12;
      for (int c = 1; c <= 60 && stores < 2; c++) begin
         @(negedge clk);
         if (c <= rel) begin
            check_eq({tag, "_rst_memwrite"}, {31'd0, memwrite}, 32'd0);
            check_eq({tag, "_rst_dataadr"}, dataadr, 32'd5);
            if (c == rel) begin
               #2 reset = 1'b0;
            end
         end else if (memwrite) begin
            stores++;
            if (stores == 1) begin
               check_eq({tag, "_st1_cycle"}, c, first_exp);
               check_eq({tag, "_st1_adr"}, dataadr, 32'd80);
               check_eq({tag, "_st1_dat"}, writedata, 32'd7);
            end else begin
               check_eq({tag, "_st2_adr"}, dataadr, 32'd84);
               check_eq({tag, "_st2_dat"}, writedata, 32'd7);
            end
         end else if (stores == 1 && c == first_exp + 1) begin
            check_eq({tag, "_lw_adr"}, dataadr, 32'd80);
         end
      end
      check_eq({tag, "_nstores"}, stores, 32'd2);
   endtask

   initial begin
      reset = 1'b1;
      #1;
      for (int i = 0; i < 64; i++)
         dut.imem[i] = (i < 18) ? std_prog[i] : 32'h0;

      // Reset held to 22 ns, then the full standard program
      run_std("boot", 2);

      // Run 5 instructions, abort the 6th with one reset edge, expect a clean restart
      reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_eq("mid_pre_memwrite", {31'd0, memwrite}, 32'd0);
      end
      reset = 1'b1;
      run_std("midrst", 1);

      // $0 stays zero after addi $0,$0,5
      reset = 1'b1;
      for (int i = 0; i < 64; i++)
         dut.imem[i] = 32'h0;
      dut.imem[0] = 32'h20000005;
      dut.imem[1] = 32'hac000000;
      @(negedge clk);
      check_eq("r0_rst_memwrite", {31'd0, memwrite}, 32'd0);
      check_eq("r0_rst_dataadr", dataadr, 32'd5);
      #2 reset = 1'b0;
      @(negedge clk);
      check_eq("r0_st_memwrite", {31'd0, memwrite}, 32'd1);
      check_eq("r0_st_adr", dataadr, 32'd0);
      check_eq("r0_st_dat", writedata, 32'd0);

      // Unsupported opcode at PC 0 shaped like add $2,$2,$2; $2 holds 7 from the lw above
      reset = 1'b1;
      dut.imem[0] = 32'hfc421020;
      dut.imem[1] = 32'hac020060;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("nop_memwrite", {31'd0, memwrite}, 32'd0);
      @(negedge clk);
      check_eq("nop_next_memwrite", {31'd0, memwrite}, 32'd1);
      check_eq("nop_next_adr", dataadr, 32'h60);
      check_eq("nop_reg_kept", writedata, 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
